// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage in-order pipeline: stage holds, bubbles,
// branch redirects (deferred across memory stalls) and saturating perf counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pend_valid_q=0, no redirect waiting
// PEND  | pend_valid_q=1, redirect captured during a MEM stall, issue on release
module pipeline_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_stall_req,
  input  logic              id_stall_req,
  input  logic              mem_stall_req,
  input  logic              ex_br_taken,
  input  logic [ADDR_W-1:0] ex_br_target,
  output logic              pc_stall,
  output logic              ifid_stall,
  output logic              ifid_flush,
  output logic              idex_stall,
  output logic              id_stall,
  output logic              branch_interception,
  output logic              exmem_stall,
  output logic              memwb_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_redirect_addr,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_count_q, flush_count_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q   <= 1'b0;
      pend_target_q  <= '0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      pend_valid_q   <= pend_valid_d;
      pend_target_q  <= pend_target_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  // Only the first redirect seen during a stall is kept; later ones are from wrong-path code.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    if (mem_stall_req) begin
      if (!pend_valid_q && ex_br_taken) begin
        pend_valid_d  = 1'b1;
        pend_target_d = ex_br_target;
      end
    end else if (pend_valid_q) begin
      pend_valid_d = 1'b0;
    end

    stall_cycles_d = stall_cycles_q;
    if (pc_stall && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);

    flush_count_d = flush_count_q;
    if (pc_redirect && (flush_count_q != '1))
      flush_count_d = flush_count_q + CNT_W'(1);
  end

  always_comb begin
    pc_stall            = 1'b0;
    ifid_stall          = 1'b0;
    ifid_flush          = 1'b0;
    idex_stall          = 1'b0;
    id_stall            = 1'b0;
    branch_interception = 1'b0;
    exmem_stall         = 1'b0;
    memwb_stall         = 1'b0;
    pc_redirect         = 1'b0;
    pc_redirect_addr    = '0;
    if (rst) begin
      pc_redirect_addr = '0;
    end else if (mem_stall_req) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_stall = 1'b1;
    end else if (pend_valid_q) begin
      branch_interception = 1'b1;
      ifid_flush          = 1'b1;
      pc_redirect         = 1'b1;
      pc_redirect_addr    = pend_target_q;
    end else if (ex_br_taken) begin
      branch_interception = 1'b1;
      ifid_flush          = 1'b1;
      pc_redirect         = 1'b1;
      pc_redirect_addr    = ex_br_target;
    end else if (id_stall_req) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      id_stall   = 1'b1;
    end else if (if_stall_req) begin
      pc_stall   = 1'b1;
      ifid_flush = 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: vector table through a scoreboard queue,
// plus hand sequences for reset during a pending redirect and counter saturation.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall_req, id_stall_req, mem_stall_req, ex_br_taken;
  logic [31:0] ex_br_target;
  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, id_stall;
  logic        branch_interception, exmem_stall, memwb_stall, pc_redirect;
  logic [31:0] pc_redirect_addr, stall_cycles, flush_count;
  logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_id_stall;
  logic        s_bi, s_exmem_stall, s_memwb_stall, s_pc_redirect;
  logic [31:0] s_addr;
  logic [3:0]  s_stall_cycles, s_flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.ADDR_W(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .mem_stall_req(mem_stall_req), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
    .idex_stall(idex_stall), .id_stall(id_stall),
    .branch_interception(branch_interception),
    .exmem_stall(exmem_stall), .memwb_stall(memwb_stall),
    .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_ctrl #(.ADDR_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .if_stall_req(if_stall_req), .id_stall_req(id_stall_req),
    .mem_stall_req(mem_stall_req), .ex_br_taken(ex_br_taken),
    .ex_br_target(ex_br_target),
    .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
    .idex_stall(s_idex_stall), .id_stall(s_id_stall),
    .branch_interception(s_bi),
    .exmem_stall(s_exmem_stall), .memwb_stall(s_memwb_stall),
    .pc_redirect(s_pc_redirect), .pc_redirect_addr(s_addr),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // {pc_stall, ifid_stall, ifid_flush, idex_stall, id_stall, branch_interception,
  //  exmem_stall, memwb_stall, pc_redirect}
  localparam logic [8:0] C_IDLE = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] C_HOLD = 9'b1_1_0_1_0_0_1_1_0;
  localparam logic [8:0] C_REDR = 9'b0_0_1_0_0_1_0_0_1;
  localparam logic [8:0] C_IDST = 9'b1_1_0_0_1_0_0_0_0;
  localparam logic [8:0] C_IFST = 9'b1_0_1_0_0_0_0_0_0;

  typedef struct {
    logic        ifs, ids, mems, br;
    logic [31:0] tgt;
    logic [8:0]  ctl;
    logic [31:0] addr, sc, fc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];

  function automatic vec_t mk(logic ifs, logic ids, logic mems, logic br, logic [31:0] tgt,
                              logic [8:0] ctl, logic [31:0] addr, logic [31:0] sc,
                              logic [31:0] fc);
    vec_t v;
    v.ifs = ifs; v.ids = ids; v.mems = mems; v.br = br; v.tgt = tgt;
    v.ctl = ctl; v.addr = addr; v.sc = sc; v.fc = fc;
    return v;
  endfunction

  function automatic logic [8:0] ctl_now();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, id_stall, branch_interception,
            exmem_stall, memwb_stall, pc_redirect};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ifs, input logic ids, input logic mems, input logic br,
                       input logic [31:0] tgt);
    if_stall_req = ifs; id_stall_req = ids; mem_stall_req = mems;
    ex_br_taken = br; ex_br_target = tgt;
  endtask

  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    @(negedge clk);
    drive(v.ifs, v.ids, v.mems, v.br, v.tgt);
    sb_q.push_back(v);
    #1;
    e = sb_q.pop_front();
    chk({tag, " ctl"}, {23'd0, ctl_now()}, {23'd0, e.ctl});
    chk({tag, " addr"}, pc_redirect_addr, e.addr);
    chk({tag, " stall_cycles"}, stall_cycles, e.sc);
    chk({tag, " flush_count"}, flush_count, e.fc);
    if (branch_interception && id_stall) chk({tag, " bi_vs_id_stall"}, 32'd1, 32'd0);
  endtask

  initial begin
    // Reset with busy inputs: every control must still read 0.
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    #2;
    chk("reset ctl", {23'd0, ctl_now()}, 32'd0);
    chk("reset addr", pc_redirect_addr, 32'd0);
    chk("reset stall_cycles", stall_cycles, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) vecs.push_back(mk(0,0,0,0,32'h0, C_IDLE, 0, 0, 0));
    vecs.push_back(mk(0,1,0,0,32'h0,      C_IDST, 0,          0, 0));
    vecs.push_back(mk(0,1,0,0,32'h0,      C_IDST, 0,          1, 0));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          2, 0));
    vecs.push_back(mk(0,1,0,1,32'h1040,   C_REDR, 32'h1040,   2, 0));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          2, 1));
    vecs.push_back(mk(0,0,1,0,32'h0,      C_HOLD, 0,          2, 1));
    vecs.push_back(mk(0,0,1,1,32'h200,    C_HOLD, 0,          3, 1));
    vecs.push_back(mk(0,0,1,1,32'h300,    C_HOLD, 0,          4, 1));
    vecs.push_back(mk(1,1,0,1,32'h400,    C_REDR, 32'h200,    5, 1));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          5, 2));
    vecs.push_back(mk(1,0,0,0,32'h0,      C_IFST, 0,          5, 2));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          6, 2));
    vecs.push_back(mk(0,0,1,1,32'h500,    C_HOLD, 0,          6, 2));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_REDR, 32'h500,    7, 2));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          7, 3));
    vecs.push_back(mk(1,1,0,0,32'h0,      C_IDST, 0,          7, 3));
    vecs.push_back(mk(0,0,0,0,32'h0,      C_IDLE, 0,          8, 3));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a HOLD with a redirect pending: it must be dropped.
    apply(mk(0,0,1,1,32'h200, C_HOLD, 0, 8, 3), "rstseq hold0");
    apply(mk(0,0,1,1,32'h300, C_HOLD, 0, 9, 3), "rstseq hold1");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstseq ctl_in_reset", {23'd0, ctl_now()}, 32'd0);
    chk("rstseq stall_cycles", stall_cycles, 32'd0);
    chk("rstseq flush_count", flush_count, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;
    apply(mk(0,0,0,0,32'h0, C_IDLE, 0, 0, 0), "rstseq release0");
    apply(mk(0,0,0,0,32'h0, C_IDLE, 0, 0, 0), "rstseq release1");

    // Saturation of the narrow counter instance.
    for (int i = 0; i < 20; i++) apply(mk(1,0,0,0,32'h0, C_IFST, 0, i, 0), $sformatf("sat%0d", i));
    apply(mk(0,0,0,0,32'h0, C_IDLE, 0, 20, 0), "sat done");
    chk("sat stall_cycles_w4", {28'd0, s_stall_cycles}, 32'd15);
    apply(mk(1,0,0,0,32'h0, C_IFST, 0, 20, 0), "sat hold");
    @(negedge clk);
    chk("sat stall_cycles_w4 held", {28'd0, s_stall_cycles}, 32'd15);
    chk("sat stall_cycles_w32", stall_cycles, 32'd21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush controller for the 5-stage in-order pipeline.
- Collects stall requests from IF, ID (load-use) and MEM, plus branch-redirect events from EX.
- Drives per-stage stall and flush controls, including idex_stall, id_stall and branch_interception into the ID/EX register, and the PC redirect.
- Holds a redirect that arrives during a MEM stall until the pipeline is free to flush.
- Keeps saturating performance counters.

Parameters:
ADDR_W, 32, PC/target address width
CNT_W, 32, width of performance counters

Ports:
clk  in  1  system clock
rst  in  1  reset; asynchronous, active-high
if_stall_req  in  1  instruction fetch not ready this cycle
id_stall_req  in  1  load-use hazard detected in ID
mem_stall_req  in  1  data memory access in progress
ex_br_taken  in  1  one-cycle pulse: EX resolved a taken branch/jump needing redirect
ex_br_target  in  ADDR_W  redirect target, valid with ex_br_taken
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
ifid_flush  out  1  load bubble into IF/ID
idex_stall  out  1  hold ID/EX register
id_stall  out  1  load bubble into ID/EX (hazard bubble)
branch_interception  out  1  flush ID/EX
exmem_stall  out  1  hold EX/MEM register
memwb_stall  out  1  hold MEM/WB register
pc_redirect  out  1  load PC from pc_redirect_addr
pc_redirect_addr  out  ADDR_W  redirect target
stall_cycles  out  CNT_W  cycles with pc_stall=1, saturating
flush_count  out  CNT_W  number of redirects issued, saturating

Behaviour:
- Registered state: pend_valid, pend_target, stall_cycles, flush_count. All control outputs are combinational from the inputs and registered state (same-cycle effect).
- Reset (async, rst=1): pend_valid=0, pend_target=0, counters=0. While rst=1, every control output is 0 and pc_redirect_addr=0.
- Priority per cycle, highest first. Exactly one case applies.
  1. mem_stall_req=1 (HOLD): pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall = 1. All flush/bubble/redirect outputs = 0. If ex_br_taken=1 and pend_valid=0: latch pend_valid=1 and pend_target=ex_br_target. If pend_valid=1, ex_br_taken is ignored.
  2. pend_valid=1 (drain, first cycle with mem_stall_req=0): branch_interception=1, ifid_flush=1, pc_redirect=1, pc_redirect_addr=pend_target. All stalls=0. Clear pend_valid next edge. ex_br_taken, id_stall_req and if_stall_req are ignored.
  3. ex_br_taken=1: branch_interception=1, ifid_flush=1, pc_redirect=1, pc_redirect_addr=ex_br_target. All stalls=0. id/if requests ignored.
  4. id_stall_req=1: pc_stall=1, ifid_stall=1, id_stall=1. idex_stall=0, others 0.
  5. if_stall_req=1: pc_stall=1, ifid_flush=1, others 0.
  6. Otherwise: all control outputs 0. pc_redirect_addr=0 when pc_redirect=0.
- Invariants:
  - branch_interception and id_stall are never both 1.
  - idex_stall=1 implies branch_interception=0 and id_stall=0.
- Latency:
  - Direct redirect: 0 cycles.
  - Deferred redirect: issued in the first cycle after mem_stall_req falls.
- Counters:
  - stall_cycles increments at each edge where pc_stall=1.
  - flush_count increments at each edge where pc_redirect=1.
  - Both hold at all-ones (no wrap).
- Reset asserted mid-HOLD with pend_valid=1: pending redirect discarded, no redirect after reset release.

Test Plan:
1. Reset, then rst=0 with all inputs idle -> all controls 0, counters 0; stall_cycles stays 0 after 10 idle cycles.
2. id_stall_req=1 for 2 cycles -> pc_stall=ifid_stall=id_stall=1, idex_stall=0, each cycle; stall_cycles=2.
3. ex_br_taken=1, target=0x0000_1040, with id_stall_req=1 -> same cycle: branch_interception=1, ifid_flush=1, pc_redirect=1, addr=0x1040, id_stall=0; flush_count=1.
4. mem_stall_req=1 for 3 cycles; ex_br_taken pulses in cycle 1 (target 0x200), then again in cycle 2 (target 0x300) -> cycles 0-2: all five stalls=1, no redirect. Cycle 3 (mem low): redirect to 0x200 (not 0x300), branch_interception=1. Cycle 4: all 0.
5. As scenario 4 but rst pulsed in cycle 2 -> no redirect after release; pend_valid=0; counters 0.
6. CNT_W=4, pc_stall forced via if_stall_req for 20 cycles -> stall_cycles saturates at 15 and holds.
